vend_mngr_param: RTL

//  Parametrised vending purchase controller: accumulates inserted coin credit, services
//  buy requests against a per-product price table and holds a one-hot dispense strobe
//  for a fixed number of cycles. It then returns any remaining credit as change.

---
 rtl/vend_mngr_param.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vend_mngr_param.sv
// Vending purchase controller: accumulates coin credit, vends against a price table,
// holds a one-hot dispense strobe for VEND_CYCLES cycles, then returns remaining change.
module vend_mngr_param #(
    parameter int                NPROD       = 4,
    parameter int                PW          = 2,
    parameter int                CW          = 8,
    parameter logic [NPROD*CW-1:0] PRICES    = {8'd40, 8'd30, 8'd20, 8'd75},
    parameter int                VEND_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_valid,
    input  logic [CW-1:0]    coin_val,
    input  logic             buy,
    input  logic [PW-1:0]    product,
    input  logic             cancel,
    output logic [NPROD-1:0] vend,
    output logic             error,
    output logic             coin_reject,
    output logic             change_valid,
    output logic [CW-1:0]    change_amt,
    output logic [CW-1:0]    credit,
    output logic             busy
);

    localparam int CNTW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [NPROD-1:0]  vend_q, vend_d;
    logic              error_q, error_d;
    logic              coin_reject_q, coin_reject_d;
    logic              change_valid_q, change_valid_d;
    logic [CW-1:0]     change_amt_q, change_amt_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic              busy_q, busy_d;

    logic [CW-1:0]     price;
    logic              prod_ok;
    logic [NPROD-1:0]  prod_onehot;
    logic [CW:0]       coin_sum;

    // Price lookup by loop so an out-of-range product simply yields prod_ok=0.
    always_comb begin
        price       = '0;
        prod_ok     = 1'b0;
        prod_onehot = '0;
        for (int i = 0; i < NPROD; i++) begin
            if (product == PW'(i)) begin
                price          = PRICES[i*CW +: CW];
                prod_ok        = 1'b1;
                prod_onehot[i] = 1'b1;
            end
        end
    end

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        vend_d         = '0;
        error_d        = 1'b0;
        coin_reject_d  = 1'b0;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        credit_d       = credit_q;

        case (state_q)
            IDLE: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if (credit_q != '0) begin
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                        credit_d       = '0;
                    end
                end else if (buy) begin
                    coin_reject_d = coin_valid;
                    if (!prod_ok || credit_q < price) begin
                        error_d = 1'b1;
                    end else begin
                        credit_d = credit_q - price;
                        vend_d   = prod_onehot;
                        cnt_d    = '0;
                        state_d  = VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_sum[CW]) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[CW-1:0];
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_valid;
                if (cnt_q == CNTW'(VEND_CYCLES - 1)) begin
                    state_d = CHANGE;
                    if (credit_q != '0) begin
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                        credit_d       = '0;
                    end
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    vend_d = vend_q;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            vend_q         <= '0;
            error_q        <= 1'b0;
            coin_reject_q  <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            credit_q       <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            vend_q         <= vend_d;
            error_q        <= error_d;
            coin_reject_q  <= coin_reject_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            credit_q       <= credit_d;
            busy_q         <= busy_d;
        end
    end

    assign vend         = vend_q;
    assign error        = error_q;
    assign coin_reject  = coin_reject_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign credit       = credit_q;
    assign busy         = busy_q;

endmodule
